// File: rtl/tlc_phase_scheduler.sv
// rtl/tlc_phase_scheduler.sv - four-approach round-robin traffic phase scheduler (optional pedestrian walk phase: TLC_PED_EN)
module tlc_phase_scheduler #(
    parameter int GREEN_MIN    = 4,
    parameter int GREEN_MAX    = 10,
    parameter int YEL_TICKS    = 3,
    parameter int ALLRED_TICKS = 1,
`ifdef TLC_PED_EN
    parameter int PED_TICKS    = 5,
`endif
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       tick,
    input  logic [3:0] req,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [3:0] red,
    output logic [1:0] phase,
    output logic [3:0] pending
`ifdef TLC_PED_EN
    ,
    input  logic       ped_req,
    output logic       walk
`endif
);

    // Tick counts widened by one bit so timer+1 never wraps before comparison.
    localparam logic [CNT_W:0]   GMIN_W = (CNT_W+1)'(GREEN_MIN);
    localparam logic [CNT_W:0]   GMAX_W = (CNT_W+1)'(GREEN_MAX);
    localparam logic [CNT_W:0]   YEL_W  = (CNT_W+1)'(YEL_TICKS);
    localparam logic [CNT_W:0]   AR_W   = (CNT_W+1)'(ALLRED_TICKS);
    localparam logic [CNT_W-1:0] GMAX_T = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] AR_T   = CNT_W'(ALLRED_TICKS);
`ifdef TLC_PED_EN
    localparam logic [CNT_W:0]   PED_W  = (CNT_W+1)'(PED_TICKS);
`endif

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
`ifdef TLC_PED_EN
        ,
        S_WALK   = 2'd3
`endif
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic [1:0]       phase_n;
    logic [CNT_W:0]   tn;
    logic             step;
    logic [3:0]       phase_oh;
    logic [3:0]       others;
    logic [3:0]       set_mask;
    logic [3:0]       clr_mask;
    logic [1:0]       winner;
    logic             found;
    logic [1:0]       idx;
`ifdef TLC_PED_EN
    logic             ped_pend;
    logic             ped_done, ped_done_n;
    logic             ped_clr;
`endif

    assign step     = tick & ena;
    assign tn       = {1'b0, timer} + 1'b1;
    assign phase_oh = 4'b0001 << phase;
    assign others   = pending & ~phase_oh;
    // The approach being served cannot re-request itself while it is green.
    assign set_mask = req & ~((state == S_GREEN) ? phase_oh : 4'b0000);

    // Round-robin search starting just after the last granted approach.
    always_comb begin
        winner = phase;
        found  = 1'b0;
        idx    = phase;
        for (int i = 1; i <= 4; i++) begin
            idx = phase + 2'(i);
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Next-state, timer and grant decisions; everything moves only on a step.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        phase_n  = phase;
        clr_mask = 4'b0000;
`ifdef TLC_PED_EN
        ped_clr    = 1'b0;
        ped_done_n = ped_done;
`endif
        case (state)
            S_ALLRED: begin
                if (step) begin
`ifdef TLC_PED_EN
                    // Walk wins once; right after a walk, waiting vehicles go first.
                    if (tn >= AR_W && ped_pend && !(ped_done && pending != 4'b0000)) begin
                        state_n = S_WALK;
                        timer_n = '0;
                        ped_clr = 1'b1;
                    end else if (tn >= AR_W && pending != 4'b0000) begin
                        state_n    = S_GREEN;
                        phase_n    = winner;
                        timer_n    = '0;
                        clr_mask   = 4'b0001 << winner;
                        ped_done_n = 1'b0;
                    end else begin
                        timer_n = (tn >= AR_W) ? AR_T : tn[CNT_W-1:0];
                    end
`else
                    if (tn >= AR_W && pending != 4'b0000) begin
                        state_n  = S_GREEN;
                        phase_n  = winner;
                        timer_n  = '0;
                        clr_mask = 4'b0001 << winner;
                    end else begin
                        timer_n = (tn >= AR_W) ? AR_T : tn[CNT_W-1:0];
                    end
`endif
                end
            end
            S_GREEN: begin
                if (step) begin
                    if (others != 4'b0000 && tn >= GMIN_W && (!req[phase] || tn >= GMAX_W)) begin
                        state_n = S_YELLOW;
                        timer_n = '0;
                    end else begin
                        timer_n = (tn >= GMAX_W) ? GMAX_T : tn[CNT_W-1:0];
                    end
                end
            end
            S_YELLOW: begin
                if (step) begin
                    if (tn == YEL_W) begin
                        state_n = S_ALLRED;
                        timer_n = '0;
                    end else begin
                        timer_n = tn[CNT_W-1:0];
                    end
                end
            end
`ifdef TLC_PED_EN
            S_WALK: begin
                if (step) begin
                    if (tn == PED_W) begin
                        state_n    = S_ALLRED;
                        timer_n    = '0;
                        ped_done_n = 1'b1;
                    end else begin
                        timer_n = tn[CNT_W-1:0];
                    end
                end
            end
`endif
            default: begin
                state_n = S_ALLRED;
                timer_n = '0;
            end
        endcase
    end

    // Phase state register; phase resets to 3 so approach 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_ALLRED;
            timer <= '0;
            phase <= 2'd3;
        end else begin
            state <= state_n;
            timer <= timer_n;
            phase <= phase_n;
        end
    end

    // Request latches run every cycle regardless of ena; a grant clear beats a new set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 4'b0000;
        end else begin
            pending <= (pending | set_mask) & ~clr_mask;
        end
    end

`ifdef TLC_PED_EN
    // Pedestrian request latch and the once-per-clearance priority flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pend <= 1'b0;
            ped_done <= 1'b0;
        end else begin
            ped_pend <= (ped_pend | ped_req) & ~ped_clr;
            ped_done <= ped_done_n;
        end
    end

    assign walk = (state == S_WALK);
`endif

    // Lamp decode from registered state and phase only.
    always_comb begin
        green  = 4'b0000;
        yellow = 4'b0000;
        if (state == S_GREEN)  green[phase]  = 1'b1;
        if (state == S_YELLOW) yellow[phase] = 1'b1;
        red = ~(green | yellow);
    end

endmodule
